autosa_glb_intr_ctrl: RTL and testbench

//  Parametrised global interrupt controller for the GLB.
//  - NUM_SRC done-pulse bits are latched into W1C status bits.
//  - Unmasked pending bits are counted.
//  - A single core interrupt is raised either directly or through a coalescing FSM
//    (count threshold / holdoff timeout).
//  - Sticky overflow bits flag done pulses that arrive while the bit is still pending.
//  - Single clock domain; any CDC sync to falcon is instantiated outside this block.

---
 rtl/autosa_glb_intr_ctrl.sv | 99 +++++++++
 tb/tb_autosa_glb_intr_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/autosa_glb_intr_ctrl.sv
`default_nettype none
// =============================================================================
// autosa_glb_intr_ctrl - W1C status latch, pending count, coalesced core irq. Rev 1.0
// =============================================================================
module autosa_glb_intr_ctrl #(
  parameter int NUM_SRC = 16,
  parameter int CNT_W   = 5,
  parameter int TMR_W   = 16
) (
  input  logic               autosa_core_clk,
  input  logic               autosa_core_rstn,
  input  logic [NUM_SRC-1:0] src_intr_pd,
  input  logic [NUM_SRC-1:0] intr_mask,
  input  logic               sw_set_trigger,
  input  logic               sw_clr_trigger,
  input  logic               ovf_clr_trigger,
  input  logic [NUM_SRC-1:0] req_wdat,
  input  logic               coal_en,
  input  logic [CNT_W-1:0]   coal_thresh,
  input  logic [TMR_W-1:0]   coal_timeout,
  output logic [NUM_SRC-1:0] intr_status,
  output logic [NUM_SRC-1:0] ovf_status,
  output logic [CNT_W-1:0]   pending_cnt,
  output logic               core_intr
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_FIRE = 2'd2
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [NUM_SRC-1:0] r_src_q;
  logic [NUM_SRC-1:0] w_set, w_clr, w_ovf_clr, w_status_nxt, w_ovf_nxt, w_masked;
  logic [CNT_W-1:0]   w_pend, w_thr;
  logic [TMR_W-1:0]   r_timer, w_timer_nxt;

  // Set beats clear on both status and overflow so no event is ever dropped.
  assign w_set        = r_src_q | (req_wdat & {NUM_SRC{sw_set_trigger}});
  assign w_clr        = req_wdat & {NUM_SRC{sw_clr_trigger}};
  assign w_ovf_clr    = req_wdat & {NUM_SRC{ovf_clr_trigger}};
  assign w_status_nxt = w_set | (intr_status & ~w_clr);
  assign w_ovf_nxt    = (r_src_q & intr_status & ~w_clr) | (ovf_status & ~w_ovf_clr);
  assign w_masked     = intr_status & ~intr_mask;
  assign w_thr        = (coal_thresh == '0) ? CNT_W'(1) : coal_thresh;

  always_comb begin
    w_pend = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_pend = w_pend + {{(CNT_W-1){1'b0}}, w_masked[i]};
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = '0;
    if (!coal_en) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_pend != '0) w_state_nxt = ST_WAIT;
        ST_WAIT: begin
          if (w_pend == '0) begin
            w_state_nxt = ST_IDLE;
          end else if ((w_pend >= w_thr) || (r_timer >= coal_timeout)) begin
            w_state_nxt = ST_FIRE;
          end else begin
            w_timer_nxt = (r_timer == '1) ? r_timer : r_timer + TMR_W'(1);
          end
        end
        ST_FIRE: if (w_pend == '0) w_state_nxt = ST_IDLE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
    if (!autosa_core_rstn) begin
      r_src_q     <= '0;
      intr_status <= '0;
      ovf_status  <= '0;
      pending_cnt <= '0;
      core_intr   <= 1'b0;
      r_state     <= ST_IDLE;
      r_timer     <= '0;
    end else begin
      r_src_q     <= src_intr_pd;
      intr_status <= w_status_nxt;
      ovf_status  <= w_ovf_nxt;
      pending_cnt <= w_pend;
      core_intr   <= coal_en ? (w_state_nxt == ST_FIRE) : (w_pend != '0);
      r_state     <= w_state_nxt;
      r_timer     <= w_timer_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_autosa_glb_intr_ctrl.sv
`default_nettype none
// =============================================================================
// tb_autosa_glb_intr_ctrl - scoreboard bench for the GLB interrupt controller. Rev 1.0
// =============================================================================
module tb_autosa_glb_intr_ctrl;
  localparam int N  = 16;
  localparam int CW = 5;
  localparam int TW = 16;

  logic          clk = 1'b0;
  logic          rstn;
  logic [N-1:0]  src_intr_pd, intr_mask, req_wdat;
  logic          sw_set_trigger, sw_clr_trigger, ovf_clr_trigger, coal_en;
  logic [CW-1:0] coal_thresh;
  logic [TW-1:0] coal_timeout;
  logic [N-1:0]  intr_status, ovf_status;
  logic [CW-1:0] pending_cnt;
  logic          core_intr;

  autosa_glb_intr_ctrl #(.NUM_SRC(N), .CNT_W(CW), .TMR_W(TW)) dut (
    .autosa_core_clk (clk),
    .autosa_core_rstn(rstn),
    .src_intr_pd     (src_intr_pd),
    .intr_mask       (intr_mask),
    .sw_set_trigger  (sw_set_trigger),
    .sw_clr_trigger  (sw_clr_trigger),
    .ovf_clr_trigger (ovf_clr_trigger),
    .req_wdat        (req_wdat),
    .coal_en         (coal_en),
    .coal_thresh     (coal_thresh),
    .coal_timeout    (coal_timeout),
    .intr_status     (intr_status),
    .ovf_status      (ovf_status),
    .pending_cnt     (pending_cnt),
    .core_intr       (core_intr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]  st;
    logic [N-1:0]  ov;
    logic [CW-1:0] pc;
    logic          ci;
  } exp_t;

  exp_t exp_q[$];

  // Reference state: 0=IDLE 1=WAIT 2=FIRE
  logic [N-1:0]  m_srcq, m_st, m_ov;
  int            m_state, m_timer;
  int            vectors = 0;
  int            errors  = 0;

  task automatic model_reset();
    m_srcq = '0; m_st = '0; m_ov = '0; m_state = 0; m_timer = 0;
    exp_q.delete();
  endtask

  task automatic idle_inputs();
    src_intr_pd = '0; req_wdat = '0;
    sw_set_trigger = 1'b0; sw_clr_trigger = 1'b0; ovf_clr_trigger = 1'b0;
  endtask

  // Predict the post-edge outputs from the current inputs, advance one clock, compare.
  task automatic cycle();
    exp_t         e, got;
    int           pend, thr, nstate, ntimer;
    logic [N-1:0] nst, nov;
    logic         s, c;
    pend = 0;
    for (int i = 0; i < N; i++) begin
      s = m_srcq[i] | (sw_set_trigger & req_wdat[i]);
      c = sw_clr_trigger & req_wdat[i];
      nst[i] = s ? 1'b1 : (c ? 1'b0 : m_st[i]);
      nov[i] = (m_srcq[i] & m_st[i] & ~c) ? 1'b1 :
               ((ovf_clr_trigger & req_wdat[i]) ? 1'b0 : m_ov[i]);
      if (m_st[i] && !intr_mask[i]) pend++;
    end
    thr = (coal_thresh == 0) ? 1 : int'(coal_thresh);
    nstate = m_state;
    ntimer = 0;
    if (!coal_en) nstate = 0;
    else if (m_state == 0) begin
      if (pend != 0) nstate = 1;
    end else if (m_state == 1) begin
      if (pend == 0) nstate = 0;
      else if (pend >= thr || m_timer >= int'(coal_timeout)) nstate = 2;
      else ntimer = (m_timer == 65535) ? 65535 : m_timer + 1;
    end else if (pend == 0) nstate = 0;
    e.st = nst;
    e.ov = nov;
    e.pc = CW'(pend);
    e.ci = coal_en ? (nstate == 2) : (pend != 0);
    exp_q.push_back(e);
    m_srcq = src_intr_pd; m_state = nstate; m_timer = ntimer;
    @(posedge clk);
    #1;
    e   = exp_q.pop_front();
    got = {intr_status, ovf_status, pending_cnt, core_intr};
    vectors++;
    if (got !== e) begin
      errors++;
      $display("FAIL scoreboard t=%0t: got st=%h ov=%h cnt=%0d intr=%b, want st=%h ov=%h cnt=%0d intr=%b",
               $time, got.st, got.ov, got.pc, got.ci, e.st, e.ov, e.pc, e.ci);
    end
    m_st = e.st; m_ov = e.ov;
  endtask

  task automatic pulse(input logic [N-1:0] bits);
    src_intr_pd = bits;
    cycle();
    src_intr_pd = '0;
  endtask

  task automatic sw_clear_all();
    sw_clr_trigger = 1'b1; ovf_clr_trigger = 1'b1; req_wdat = '1;
    cycle();
    idle_inputs();
    repeat (2) cycle();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    idle_inputs();
    intr_mask = '0; coal_en = 1'b0; coal_thresh = '0; coal_timeout = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({intr_status, ovf_status, pending_cnt, core_intr} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got st=%h ov=%h cnt=%0d intr=%b, want all 0",
               intr_status, ovf_status, pending_cnt, core_intr);
    end
    rstn = 1'b1;
    repeat (2) cycle();
  endtask

  task automatic test_direct();
    coal_en = 1'b0; intr_mask = '0;
    pulse(16'h0004);
    cycle();
    vectors++;
    if (intr_status[2] !== 1'b1 || core_intr !== 1'b0) begin
      errors++;
      $display("FAIL direct_c2: got status2=%b intr=%b, want 1 0", intr_status[2], core_intr);
    end
    cycle();
    vectors++;
    if (core_intr !== 1'b1) begin
      errors++;
      $display("FAIL direct_c3_intr: got %b want 1", core_intr);
    end
    sw_clr_trigger = 1'b1; req_wdat = 16'h0004;
    cycle();
    idle_inputs();
    vectors++;
    if (intr_status[2] !== 1'b0 || core_intr !== 1'b1) begin
      errors++;
      $display("FAIL direct_clr: got status2=%b intr=%b, want 0 1", intr_status[2], core_intr);
    end
    cycle();
    vectors++;
    if (core_intr !== 1'b0) begin
      errors++;
      $display("FAIL direct_fall: got %b want 0", core_intr);
    end
  endtask

  task automatic test_race();
    sw_set_trigger = 1'b1; req_wdat = 16'h0020;
    cycle();
    idle_inputs();
    pulse(16'h0020);
    sw_clr_trigger = 1'b1; req_wdat = 16'h0020;
    cycle();
    idle_inputs();
    vectors++;
    if (intr_status[5] !== 1'b1 || ovf_status[5] !== 1'b0) begin
      errors++;
      $display("FAIL race_bit5: got status=%b ovf=%b, want 1 0", intr_status[5], ovf_status[5]);
    end
    sw_clear_all();
  endtask

  task automatic test_overflow();
    pulse(16'h0001);
    cycle();
    pulse(16'h0001);
    cycle();
    vectors++;
    if (ovf_status[0] !== 1'b1 || intr_status[0] !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set: got ovf=%b status=%b, want 1 1", ovf_status[0], intr_status[0]);
    end
    ovf_clr_trigger = 1'b1; req_wdat = 16'h0001;
    cycle();
    idle_inputs();
    vectors++;
    if (ovf_status[0] !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clr: got %b want 0", ovf_status[0]);
    end
    sw_clear_all();
  endtask

  task automatic test_threshold();
    coal_en = 1'b1; coal_thresh = 5'd3; coal_timeout = 16'd100;
    for (int k = 0; k < 13; k++) begin
      src_intr_pd = (k == 0) ? 16'h0001 : (k == 5) ? 16'h0002 : (k == 10) ? 16'h0004 : 16'h0000;
      cycle();
      src_intr_pd = '0;
      vectors++;
      if (core_intr !== ((k + 1 == 13) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL thresh_intr c+%0d: got %b want %b", k + 1, core_intr, k + 1 == 13);
      end
    end
    vectors++;
    if (pending_cnt !== 5'd3) begin
      errors++;
      $display("FAIL thresh_cnt: got %0d want 3", pending_cnt);
    end
    sw_clear_all();
  endtask

  task automatic test_timeout();
    coal_en = 1'b1; coal_thresh = 5'd4; coal_timeout = 16'd10;
    pulse(16'h0080);
    for (int k = 1; k < 14; k++) begin
      cycle();
      vectors++;
      if (core_intr !== ((k + 1 == 14) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL timeout_intr c+%0d: got %b want %b", k + 1, core_intr, k + 1 == 14);
      end
    end
    cycle();
    sw_clr_trigger = 1'b1; req_wdat = 16'h0080;
    cycle();
    idle_inputs();
    vectors++;
    if (intr_status[7] !== 1'b0 || core_intr !== 1'b1) begin
      errors++;
      $display("FAIL timeout_clr: got status7=%b intr=%b, want 0 1", intr_status[7], core_intr);
    end
    cycle();
    vectors++;
    if (core_intr !== 1'b0) begin
      errors++;
      $display("FAIL timeout_fall: got %b want 0", core_intr);
    end
    // Timeout of zero fires the cycle after WAIT is entered.
    coal_timeout = '0;
    pulse(16'h0080);
    repeat (4) cycle();
    vectors++;
    if (core_intr !== 1'b1) begin
      errors++;
      $display("FAIL timeout_zero: got %b want 1", core_intr);
    end
    sw_clear_all();
  endtask

  task automatic test_coal_off();
    coal_en = 1'b1; coal_thresh = 5'd8; coal_timeout = 16'd50;
    pulse(16'h0002);
    repeat (4) cycle();
    coal_en = 1'b0;
    cycle();
    vectors++;
    if (core_intr !== 1'b1) begin
      errors++;
      $display("FAIL coal_off_direct: got %b want 1", core_intr);
    end
    coal_en = 1'b1;
    repeat (3) cycle();
    sw_clear_all();
  endtask

  task automatic test_mask_reset();
    coal_en = 1'b0; intr_mask = 16'h0008;
    pulse(16'h0008);
    repeat (3) cycle();
    vectors++;
    if (core_intr !== 1'b0 || pending_cnt !== '0 || intr_status[3] !== 1'b1) begin
      errors++;
      $display("FAIL mask_hold: got intr=%b cnt=%0d status3=%b, want 0 0 1",
               core_intr, pending_cnt, intr_status[3]);
    end
    intr_mask = '0;
    cycle();
    vectors++;
    if (pending_cnt !== 5'd1 || core_intr !== 1'b1) begin
      errors++;
      $display("FAIL unmask: got cnt=%0d intr=%b, want 1 1", pending_cnt, core_intr);
    end
    coal_en = 1'b1; coal_thresh = 5'd4; coal_timeout = 16'd50;
    pulse(16'h0010);
    repeat (3) cycle();
    #2 rstn = 1'b0;
    #1;
    vectors++;
    if ({intr_status, ovf_status, pending_cnt, core_intr} !== '0) begin
      errors++;
      $display("FAIL async_reset: got st=%h ov=%h cnt=%0d intr=%b, want all 0",
               intr_status, ovf_status, pending_cnt, core_intr);
    end
    @(posedge clk);
    #1;
    rstn = 1'b1;
    model_reset();
    repeat (3) cycle();
  endtask

  task automatic test_random();
    rstn = 1'b1;
    for (int k = 0; k < 300; k++) begin
      src_intr_pd     = N'($urandom & $urandom & $urandom);
      req_wdat        = N'($urandom);
      sw_set_trigger  = ($urandom_range(0, 15) == 0);
      sw_clr_trigger  = ($urandom_range(0, 5) == 0);
      ovf_clr_trigger = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 19) == 0) intr_mask = N'($urandom & $urandom);
      if ($urandom_range(0, 29) == 0) coal_en = ~coal_en;
      if ($urandom_range(0, 29) == 0) coal_thresh = CW'($urandom_range(0, 6));
      if ($urandom_range(0, 29) == 0) coal_timeout = TW'($urandom_range(0, 12));
      cycle();
    end
    idle_inputs();
    sw_clear_all();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_direct();
    test_race();
    test_overflow();
    test_threshold();
    test_timeout();
    test_coal_off();
    test_mask_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
`default_nettype wire
